hazard_scoreboard: RTL

//  Parametrised successor to the pipeline's combinational hazard detector. Tracks every in-flight register write in a
//  per-register countdown scoreboard and compares up to NUM_SRC source operands of the ID-stage instruction against it.

---
 rtl/hazard_scoreboard_pkg.sv | 18 +
 rtl/hazard_scoreboard_sb_counter.sv | 36 +++
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared hazard-scoreboard constants: register index width, FSM encodings
// and default producer latencies, also used by the forwarding unit.
package hazard_scoreboard_pkg;

    localparam int REG_FILE_DEPTH   = 5;
    localparam int WB_DIST_DEF      = 2;
    localparam int LOAD_USE_LAT_DEF = 1;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_DRAIN = 1'b1
    } hz_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// One scoreboard cell: a countdown that reloads with the larger of its
// decremented value and a new producer latency.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] dec;

    always_comb begin
        dec   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        cnt_d = dec;
        // WAW: a second producer never shortens an older one's window
        if (ld && (ld_val > dec)) begin
            cnt_d = ld_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown hazard scoreboard with forwarding-mode drain FSM.
// Define HAZARD_SCOREBOARD_STATS_EN to add stall_cycles/hazard_events.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W   = REG_FILE_DEPTH,
    parameter int NUM_REGS     = 16,
    parameter int NUM_SRC      = 3,
    parameter int WB_DIST      = WB_DIST_DEF,
    parameter int LOAD_USE_LAT = LOAD_USE_LAT_DEF,
    parameter int CNT_W        = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fwd_en,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_has_src,
    input  logic [REG_ADDR_W-1:0]         id_dest,
    input  logic                          id_wb_en,
    input  logic                          id_memread,
    input  logic                          flush,
    output logic                          hazard_detected,
    output logic                          issue,
    output logic [NUM_REGS-1:0]           sb_busy,
    output logic                          drain_active
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                   stall_cycles,
    output logic [31:0]                   hazard_events
`endif
);

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic             fwd_q;
    logic             fwd_d;
    logic             data_haz;
    logic [CNT_W-1:0] ld_val;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] ld;

    // Out-of-range source indices match no register and so never hazard
    always_comb begin
        data_haz = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (id_has_src[k] &&
                    (id_src[k*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r)) &&
                    busy[r]) begin
                    data_haz = 1'b1;
                end
            end
        end
        data_haz = data_haz & id_valid;
    end

    always_comb begin
        if (!fwd_q) begin
            ld_val = CNT_W'(WB_DIST);
        end else if (id_memread) begin
            ld_val = CNT_W'(LOAD_USE_LAT);
        end else begin
            ld_val = '0;
        end
    end

    assign hazard_detected = data_haz | drain_active;
    assign issue           = id_valid & ~hazard_detected & ~flush;
    assign sb_busy         = busy;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cell
        assign ld[r] = issue & id_wb_en & (id_dest == REG_ADDR_W'(r));

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .ld     (ld[r]),
            .ld_val (ld_val),
            .busy   (busy[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
            fwd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fwd_q   <= fwd_d;
        end
    end

    // Mode only switches once every in-flight producer has retired
    always_comb begin
        state_d = state_q;
        fwd_d   = fwd_q;
        unique case (state_q)
            HZ_RUN: begin
                if (fwd_en != fwd_q) begin
                    state_d = HZ_DRAIN;
                end
            end
            HZ_DRAIN: begin
                if (busy == '0) begin
                    state_d = HZ_RUN;
                    fwd_d   = fwd_en;
                end
            end
            default: state_d = HZ_RUN;
        endcase
    end

    always_comb begin
        drain_active = (state_q == HZ_DRAIN);
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic        stall;
    logic        stall_q;
    logic [31:0] stall_cycles_q;
    logic [31:0] hazard_events_q;

    assign stall = id_valid & hazard_detected;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q         <= 1'b0;
            stall_cycles_q  <= '0;
            hazard_events_q <= '0;
        end else begin
            stall_q <= stall;
            if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (stall && !stall_q && (hazard_events_q != 32'hFFFF_FFFF)) begin
                hazard_events_q <= hazard_events_q + 32'd1;
            end
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign hazard_events = hazard_events_q;
`endif

endmodule
